mem_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one port of the dual-port 4096x24 data memory between NUM_REQ requesters
//  (default: 0 = load/store unit, 1 = debug loader, 2 = DMA).
//  One command is accepted per cycle; the command is registered onto the memory port.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter_rr_pick.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, requester ids and the memory command record for the data-memory port arbiter.
// Memory geometry is 4096 x 24.
package mem_port_arbiter_pkg;

    localparam int HBIT_ADDR = 11;
    localparam int HBIT_DATA = 23;

    localparam int REQ_LSU = 0;
    localparam int REQ_DBG = 1;
    localparam int REQ_DMA = 2;

    localparam int NUM_REQ_DEF = 3;
    localparam int IDX_W_DEF   = 2;

    typedef struct packed {
        logic               we;
        logic [HBIT_ADDR:0] addr;
        logic [HBIT_DATA:0] wdata;
    } mem_cmd_t;

    // Round-robin successor of idx among n slots.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter.
// Requesters drive through the master modport; the arbiter uses the slave modport.
interface mem_port_arbiter_if #(parameter int NUM_REQ = 3);
    import mem_port_arbiter_pkg::*;

    logic               iw_req    [0:NUM_REQ-1];
    logic               iw_lock   [0:NUM_REQ-1];
    logic               iw_we     [0:NUM_REQ-1];
    logic [HBIT_ADDR:0] iw_addr   [0:NUM_REQ-1];
    logic [HBIT_DATA:0] iw_wdata  [0:NUM_REQ-1];
    logic               ow_gnt    [0:NUM_REQ-1];
    logic               or_rvalid [0:NUM_REQ-1];
    logic [HBIT_DATA:0] ow_rdata;

    modport master (
        output iw_req, iw_lock, iw_we, iw_addr, iw_wdata,
        input  ow_gnt, or_rvalid, ow_rdata
    );

    modport slave (
        input  iw_req, iw_lock, iw_we, iw_addr, iw_wdata,
        output ow_gnt, or_rvalid, ow_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin pick: a valid lock owner wins exclusively,
// otherwise the first requester at or after the pointer (mod NUM_REQ).
module mem_port_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               lock_vld,
    input  logic [IDX_W-1:0]   lock_idx,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    int j;

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        if (lock_vld) begin
            any     = req[lock_idx];
            win_idx = lock_idx;
        end else begin
            // Scan from farthest to nearest so the nearest requester is the last write.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = (int'(ptr) + k) % NUM_REQ;
                if (req[j]) begin
                    any     = 1'b1;
                    win_idx = IDX_W'(j);
                end
            end
        end
        if (any) begin
            gnt[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_REQ requesters,
// with lock-based atomic sequences and a 2-cycle tagged read-return pipeline.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    mem_port_arbiter_if.slave  rq,
    output logic               or_mem_we,
    output logic [HBIT_ADDR:0] or_mem_addr,
    output logic [HBIT_DATA:0] or_mem_wdata,
    input  logic [HBIT_DATA:0] iw_mem_rdata
);

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] lock_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] rvalid_reg;
    logic [NUM_REQ-1:0] rvalid_next;

    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   owner_reg;
    logic [IDX_W-1:0]   owner_next;
    logic               owner_vld_reg;
    logic               owner_vld_next;
    logic               lock_hold;

    logic [IDX_W-1:0]   win_idx;
    logic               any;

    mem_cmd_t           cmd_reg;
    mem_cmd_t           cmd_next;

    logic [1:0]         tag_vld_reg;
    logic [IDX_W-1:0]   tag_idx_reg [0:1];
    logic               tag_vld_next;
    logic [IDX_W-1:0]   tag_idx_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_vec[gi]      = rq.iw_req[gi];
            assign lock_vec[gi]     = rq.iw_lock[gi];
            assign rq.ow_gnt[gi]    = gnt_vec[gi];
            assign rq.or_rvalid[gi] = rvalid_reg[gi];
            assign rvalid_next[gi]  = tag_vld_reg[1] & (tag_idx_reg[1] == IDX_W'(gi));
        end
    endgenerate

    assign rq.ow_rdata    = iw_mem_rdata;
    assign or_mem_we      = cmd_reg.we;
    assign or_mem_addr    = cmd_reg.addr;
    assign or_mem_wdata   = cmd_reg.wdata;

    // The owner keeps exclusivity while it requests or still holds its lock line;
    // dropping both releases it in the same cycle so RR can pick someone else.
    assign lock_hold = owner_vld_reg & (req_vec[owner_reg] | lock_vec[owner_reg]);

    mem_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req_vec),
        .ptr      (ptr_reg),
        .lock_vld (lock_hold),
        .lock_idx (owner_reg),
        .gnt      (gnt_vec),
        .win_idx  (win_idx),
        .any      (any)
    );

    always_comb begin
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        owner_vld_next = lock_hold;
        cmd_next       = cmd_reg;
        cmd_next.we    = 1'b0;
        tag_vld_next   = 1'b0;
        tag_idx_next   = '0;
        if (any) begin
            ptr_next       = IDX_W'(rr_next(int'(win_idx), NUM_REQ));
            owner_next     = win_idx;
            owner_vld_next = lock_vec[win_idx];
            cmd_next.we    = rq.iw_we[win_idx];
            cmd_next.addr  = rq.iw_addr[win_idx];
            cmd_next.wdata = rq.iw_wdata[win_idx];
            tag_vld_next   = ~rq.iw_we[win_idx];
            tag_idx_next   = win_idx;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            ptr_reg        <= '0;
            owner_reg      <= '0;
            owner_vld_reg  <= 1'b0;
            cmd_reg        <= '0;
            tag_vld_reg    <= '0;
            tag_idx_reg[0] <= '0;
            tag_idx_reg[1] <= '0;
            rvalid_reg     <= '0;
        end else begin
            ptr_reg        <= ptr_next;
            owner_reg      <= owner_next;
            owner_vld_reg  <= owner_vld_next;
            cmd_reg        <= cmd_next;
            tag_vld_reg    <= {tag_vld_reg[0], tag_vld_next};
            tag_idx_reg[0] <= tag_idx_next;
            tag_idx_reg[1] <= tag_idx_reg[0];
            rvalid_reg     <= rvalid_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a request-level model of grants, port commands and read returns.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NR = 3;

    logic               iw_clk;
    logic               iw_rst_n;
    logic               or_mem_we;
    logic [HBIT_ADDR:0] or_mem_addr;
    logic [HBIT_DATA:0] or_mem_wdata;
    logic [HBIT_DATA:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.NUM_REQ(NR)) bus ();

    mem_port_arbiter #(.NUM_REQ(NR), .IDX_W(2)) dut (
        .iw_clk       (iw_clk),
        .iw_rst_n     (iw_rst_n),
        .rq           (bus),
        .or_mem_we    (or_mem_we),
        .or_mem_addr  (or_mem_addr),
        .or_mem_wdata (or_mem_wdata),
        .iw_mem_rdata (mem_rdata)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    // Memory environment: address sampled one edge after the command register, data out one edge later.
    logic [HBIT_DATA:0] mem_arr [0:4095];
    logic [HBIT_DATA:0] mem_rd1;
    always @(posedge iw_clk) begin
        if (or_mem_we === 1'b1) mem_arr[or_mem_addr] <= or_mem_wdata;
        mem_rd1   <= mem_arr[or_mem_addr];
        mem_rdata <= mem_rd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] gnt_vec();
        logic [31:0] r = '0;
        for (int i = 0; i < NR; i++) r[i] = bus.ow_gnt[i];
        return r;
    endfunction

    function automatic logic [31:0] rv_vec();
        logic [31:0] r = '0;
        for (int i = 0; i < NR; i++) r[i] = bus.or_rvalid[i];
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; int idx; logic [HBIT_DATA:0] data; } rd_t;
    rd_t                rd_q[$];
    logic [HBIT_DATA:0] shadow [0:4095];
    int                 m_ptr, m_owner, live, n;
    logic               exp_we;
    logic [HBIT_ADDR:0] exp_addr;
    logic [HBIT_DATA:0] exp_wdata;

    function automatic int model_pick();
        if (m_owner >= 0 && (bus.iw_req[m_owner] || bus.iw_lock[m_owner]))
            return bus.iw_req[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            int j = (m_ptr + k) % NR;
            if (bus.iw_req[j]) return j;
        end
        return -1;
    endfunction

    initial begin
        logic [31:0] exp_rv;
        logic [HBIT_DATA:0] exp_rd;
        int w;
        for (int a = 0; a < 4096; a++) begin
            shadow[a]  = 24'((a * 32'h9E37 + 7) ^ 32'h5A5A5A);
            mem_arr[a] <= 24'((a * 32'h9E37 + 7) ^ 32'h5A5A5A);
        end
        shadow[16]  = 24'hABCDEF;
        mem_arr[16] <= 24'hABCDEF;
        live = 0; n = 0; m_ptr = 0; m_owner = -1;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        forever begin
            @(negedge iw_clk);
            if (live != 0) begin
                chk("mem_we", 32'(or_mem_we), 32'(exp_we));
                chk("mem_addr", 32'(or_mem_addr), 32'(exp_addr));
                chk("mem_wdata", 32'(or_mem_wdata), 32'(exp_wdata));
                exp_rv = '0;
                exp_rd = '0;
                if (rd_q.size() > 0 && rd_q[0].due == n) begin
                    exp_rv[rd_q[0].idx] = 1'b1;
                    exp_rd = rd_q[0].data;
                    void'(rd_q.pop_front());
                end
                chk("rvalid", rv_vec(), exp_rv);
                if (exp_rv != 0) chk("rdata", 32'(bus.ow_rdata), 32'(exp_rd));
            end
            if (!iw_rst_n) begin
                live = 1; m_ptr = 0; m_owner = -1;
                exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
                rd_q.delete();
            end else if (live != 0) begin
                w = model_pick();
                chk("gnt", gnt_vec(), (w >= 0) ? (32'd1 << w) : 32'd0);
                if (w >= 0) begin
                    exp_we    = bus.iw_we[w];
                    exp_addr  = bus.iw_addr[w];
                    exp_wdata = bus.iw_wdata[w];
                    m_ptr     = (w + 1) % NR;
                    m_owner   = bus.iw_lock[w] ? w : -1;
                    if (bus.iw_we[w]) shadow[bus.iw_addr[w]] = bus.iw_wdata[w];
                    else rd_q.push_back('{due: n + 3, idx: w, data: shadow[bus.iw_addr[w]]});
                end else begin
                    exp_we = 1'b0;
                    if (m_owner >= 0 && !bus.iw_lock[m_owner] && !bus.iw_req[m_owner]) m_owner = -1;
                end
            end
            n++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [HBIT_ADDR:0] a, input logic [HBIT_DATA:0] d);
        bus.iw_req[i]   = 1'b1;
        bus.iw_we[i]    = we;
        bus.iw_addr[i]  = a;
        bus.iw_wdata[i] = d;
    endtask

    task automatic rand_cmd(input int i);
        set_cmd(i, 1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 15)), 24'($urandom));
    endtask

    logic acc [0:NR-1];

    initial begin
        iw_rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.iw_lock[i] = 1'b0;
            set_cmd(i, 1'b0, 12'h100 + 12'(i), '0);
        end
        // Reset held with every requester active.
        tick(); tick();
        @(negedge iw_clk);
        chk("rst_mem_we", 32'(or_mem_we), 32'd0);
        chk("rst_mem_addr", 32'(or_mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(or_mem_wdata), 32'd0);
        chk("rst_rvalid", rv_vec(), 32'd0);
        tick();
        iw_rst_n = 1'b1;

        // Fairness: all three requesting for six cycles.
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            @(negedge iw_clk);
            chk("rr_gnt", gnt_vec(), 32'd1 << (k % 3));
            if (k > 0) chk("rr_addr", 32'(or_mem_addr), 32'h100 + 32'((k - 1) % 3));
        end
        tick();
        for (int i = 0; i < NR; i++) bus.iw_req[i] = 1'b0;
        @(negedge iw_clk);
        chk("rr_addr_last", 32'(or_mem_addr), 32'h102);
        repeat (4) tick();

        // Read latency on the debug requester.
        set_cmd(REQ_DBG, 1'b0, 12'h010, '0);
        @(negedge iw_clk);
        chk("lat_gnt", gnt_vec(), 32'b010);
        tick();
        bus.iw_req[REQ_DBG] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge iw_clk);
            chk("lat_rvalid", rv_vec(), (k == 2) ? 32'b010 : 32'd0);
            if (k == 2) chk("lat_rdata", 32'(bus.ow_rdata), 32'hABCDEF);
            tick();
        end

        // Write then read-back on the next cycle.
        set_cmd(REQ_LSU, 1'b1, 12'h020, 24'h123456);
        @(negedge iw_clk);
        chk("raw_wr_gnt", gnt_vec(), 32'b001);
        tick();
        bus.iw_we[REQ_LSU] = 1'b0;
        @(negedge iw_clk);
        chk("raw_rd_gnt", gnt_vec(), 32'b001);
        tick();
        bus.iw_req[REQ_LSU] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge iw_clk);
            chk("raw_rvalid", rv_vec(), (k == 2) ? 32'b001 : 32'd0);
            if (k == 2) chk("raw_rdata", 32'(bus.ow_rdata), 32'h123456);
            tick();
        end
        repeat (2) tick();

        // Locked read-modify-write by the DMA requester.
        set_cmd(REQ_DMA, 1'b0, 12'h030, '0);
        bus.iw_lock[REQ_DMA] = 1'b1;
        @(negedge iw_clk);
        chk("lock_first_gnt", gnt_vec(), 32'b100);
        tick();
        set_cmd(REQ_DMA, 1'b1, 12'h030, 24'h0FEDCB);
        set_cmd(REQ_LSU, 1'b0, 12'h040, '0);
        set_cmd(REQ_DBG, 1'b0, 12'h041, '0);
        @(negedge iw_clk);
        chk("lock_wr_gnt", gnt_vec(), 32'b100);
        tick();
        bus.iw_req[REQ_DMA] = 1'b0;
        @(negedge iw_clk);
        chk("lock_hold_gnt", gnt_vec(), 32'd0);
        tick();
        bus.iw_lock[REQ_DMA] = 1'b0;
        @(negedge iw_clk);
        chk("lock_release_gnt", gnt_vec(), 32'b001);
        tick();
        bus.iw_req[REQ_LSU] = 1'b0;
        @(negedge iw_clk);
        chk("lock_next_gnt", gnt_vec(), 32'b010);
        tick();
        bus.iw_req[REQ_DBG] = 1'b0;
        repeat (4) tick();

        // Reset arriving while a read is in flight.
        set_cmd(REQ_DBG, 1'b0, 12'h050, '0);
        @(negedge iw_clk);
        chk("rstf_gnt", gnt_vec(), 32'b010);
        tick();
        bus.iw_req[REQ_DBG] = 1'b0;
        iw_rst_n = 1'b0;
        tick();
        iw_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge iw_clk);
            chk("rstf_rvalid", rv_vec(), 32'd0);
            tick();
        end
        for (int i = 0; i < NR; i++) bus.iw_req[i] = 1'b1;
        @(negedge iw_clk);
        chk("rstf_ptr_gnt", gnt_vec(), 32'b001);
        tick();
        for (int i = 0; i < NR; i++) bus.iw_req[i] = 1'b0;
        repeat (3) tick();

        // Random traffic; commands stay stable until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge iw_clk);
            for (int i = 0; i < NR; i++) acc[i] = bus.iw_req[i] & bus.ow_gnt[i] & iw_rst_n;
            tick();
            iw_rst_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < NR; i++) begin
                if (bus.iw_req[i] && acc[i]) begin
                    if ($urandom_range(0, 1) != 0) rand_cmd(i);
                    else bus.iw_req[i] = 1'b0;
                end else if (!bus.iw_req[i] && $urandom_range(0, 2) == 0) begin
                    rand_cmd(i);
                end
                bus.iw_lock[i] = ($urandom_range(0, 5) == 0);
            end
        end
        iw_rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            bus.iw_req[i]  = 1'b0;
            bus.iw_lock[i] = 1'b0;
        end
        repeat (6) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
